// File: rtl/guia_0501_checker.sv
// Response checker for Guia_0501 2-input logic cells: judges (a, b, s) observations
// against a 4-entry truth table and reports pass/fail once every input row is covered.
//
// state   | meaning
// IDLE    | waiting for start; observations ignored
// RUN     | accepting observations, tracking coverage and mismatches
// DONE    | all four rows covered; result held until restart or reset
module guia_0501_checker #(
  parameter logic [3:0] TRUTH = 4'b0110,
  parameter int         CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a,
  input  logic             b,
  input  logic             s,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [3:0]       seen,
  output logic             mismatch
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] ERR_MAX = '1;
  localparam logic [CNT_W-1:0] ERR_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [3:0]       seen_q, seen_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             mm_q, mm_d;

  logic [1:0] idx;
  logic [3:0] row_onehot;
  logic       run;
  logic       xfer;
  logic       bad;

  assign idx        = {a, b};
  assign row_onehot = 4'b0001 << idx;
  assign run        = (state_q == ST_RUN);
  assign xfer       = in_valid && run;
  assign bad        = xfer && (s != TRUTH[idx]);

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    seen_d  = seen_q;
    done_d  = done_q;
    pass_d  = pass_q;
    mm_d    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          err_d   = '0;
          seen_d  = 4'h0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      ST_RUN: begin
        // start is deliberately ignored while a run is in progress
        if (xfer) begin
          seen_d = seen_q | row_onehot;
          if (bad) begin
            mm_d = 1'b1;
            if (err_q != ERR_MAX) begin
              err_d = err_q + ERR_ONE;
            end
          end
          if (seen_d == 4'hF) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      err_q   <= '0;
      seen_q  <= 4'h0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      seen_q  <= seen_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      mm_q    <= mm_d;
    end
  end

  assign in_ready  = run;
  assign busy      = run;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign seen      = seen_q;
  assign mismatch  = mm_q;

endmodule

// File: tb/tb_guia_0501_checker.sv
// Scoreboard bench for guia_0501_checker: a default instance plus a CNT_W=2 instance
// for counter saturation; expected post-transfer outputs are queued and checked by monitors.
module tb_guia_0501_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start_m, start_s, in_valid, a, b, s;

  logic       m_in_ready, m_busy, m_done, m_pass, m_mismatch;
  logic [7:0] m_err;
  logic [3:0] m_seen;
  logic       s_in_ready, s_busy, s_done, s_pass, s_mismatch;
  logic [1:0] s_err;
  logic [3:0] s_seen;

  guia_0501_checker #(.TRUTH(4'b0110), .CNT_W(8)) u_main (
    .clk(clk), .rst_n(rst_n), .start(start_m), .in_valid(in_valid), .in_ready(m_in_ready),
    .a(a), .b(b), .s(s), .busy(m_busy), .done(m_done), .pass(m_pass),
    .err_count(m_err), .seen(m_seen), .mismatch(m_mismatch)
  );

  guia_0501_checker #(.TRUTH(4'b0110), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start_s), .in_valid(in_valid), .in_ready(s_in_ready),
    .a(a), .b(b), .s(s), .busy(s_busy), .done(s_done), .pass(s_pass),
    .err_count(s_err), .seen(s_seen), .mismatch(s_mismatch)
  );

  typedef struct packed {
    logic [3:0] seen;
    logic [7:0] err;
    logic       mm;
    logic       done;
    logic       pass;
  } exp_t;

  exp_t q_m[$];
  exp_t q_s[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input bit sat, input logic ia, input logic ib, input logic is,
                      input logic [3:0] es, input logic [7:0] ee, input logic em,
                      input logic ed, input logic ep);
    exp_t e;
    a = ia; b = ib; s = is; in_valid = 1'b1;
    e.seen = es; e.err = ee; e.mm = em; e.done = ed; e.pass = ep;
    if (sat) q_s.push_back(e);
    else q_m.push_back(e);
    tick();
  endtask

  task automatic chk_clear(input string nm, input bit sat);
    if (sat) chk(nm, {s_in_ready, s_busy, s_done, s_pass, s_mismatch, 6'h0, s_err, s_seen}, 32'h0);
    else chk(nm, {m_in_ready, m_busy, m_done, m_pass, m_mismatch, m_err, m_seen}, 32'h0);
  endtask

  // Monitors: a transfer seen before an edge is judged at the following negedge.
  bit pend_m = 1'b0;
  bit pend_s = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (pend_m) begin
      if (q_m.size() == 0) begin
        tests++; fails++;
        $display("FAIL main_unexpected_transfer: seen=%0h err=%0h", m_seen, m_err);
      end else begin
        e = q_m.pop_front();
        chk("main_seen", m_seen, e.seen);
        chk("main_err", m_err, e.err);
        chk("main_mismatch", m_mismatch, e.mm);
        chk("main_done", m_done, e.done);
        chk("main_pass", m_pass, e.pass);
      end
    end
    pend_m = rst_n && in_valid && m_in_ready;
  end

  always @(negedge clk) begin
    exp_t e;
    if (pend_s) begin
      if (q_s.size() == 0) begin
        tests++; fails++;
        $display("FAIL sat_unexpected_transfer: seen=%0h err=%0h", s_seen, s_err);
      end else begin
        e = q_s.pop_front();
        chk("sat_seen", s_seen, e.seen);
        chk("sat_err", {6'h0, s_err}, e.err);
        chk("sat_mismatch", s_mismatch, e.mm);
        chk("sat_done", s_done, e.done);
        chk("sat_pass", s_pass, e.pass);
      end
    end
    pend_s = rst_n && in_valid && s_in_ready;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset held with start and in_valid asserted
    rst_n = 1'b0; start_m = 1'b1; start_s = 1'b1; in_valid = 1'b1; a = 0; b = 0; s = 1;
    tick(); tick();
    chk_clear("reset_main", 0);
    chk_clear("reset_sat", 1);
    rst_n = 1'b1; start_m = 1'b0; start_s = 1'b0;
    tick(); tick();
    chk("idle_hold_main", {m_in_ready, m_busy, m_seen, m_err}, 32'h0);

    // XOR pass, with an ignored start mid-run
    start_m = 1'b1; in_valid = 1'b0; tick(); start_m = 1'b0;
    chk("start_ready", {m_in_ready, m_busy, m_done, m_seen}, {1'b1, 1'b1, 1'b0, 4'h0});
    send(0, 0, 0, 0, 4'h1, 8'd0, 0, 0, 0);
    in_valid = 1'b0; start_m = 1'b1; tick(); start_m = 1'b0;
    chk("run_start_ignored", {m_busy, m_seen}, {1'b1, 4'h1});
    send(0, 0, 1, 1, 4'h3, 8'd0, 0, 0, 0);
    send(0, 1, 0, 1, 4'h7, 8'd0, 0, 0, 0);
    send(0, 1, 1, 0, 4'hF, 8'd0, 0, 1, 1);
    chk("done_ready_low", {m_in_ready, m_busy}, 2'b00);
    tick(); in_valid = 1'b0;
    chk("done_hold", {m_done, m_pass, m_seen}, {1'b1, 1'b1, 4'hF});

    // restart from DONE, then single fault on row 11
    start_m = 1'b1; tick(); start_m = 1'b0;
    chk("restart_clear", {m_in_ready, m_done, m_pass, m_seen}, {1'b1, 1'b0, 1'b0, 4'h0});
    send(0, 0, 0, 0, 4'h1, 8'd0, 0, 0, 0);
    send(0, 0, 1, 1, 4'h3, 8'd0, 0, 0, 0);
    send(0, 1, 0, 1, 4'h7, 8'd0, 0, 0, 0);
    send(0, 1, 1, 1, 4'hF, 8'd1, 1, 1, 0);
    in_valid = 1'b0; tick();
    chk("mismatch_one_cycle", m_mismatch, 1'b0);
    chk("fault_err_hold", m_err, 8'd1);

    // ignored input in DONE and on the start edge, then repeats
    in_valid = 1'b1; a = 0; b = 0; s = 1;
    tick(); tick();
    chk("done_ignores_input", {m_err, m_seen}, {8'd1, 4'hF});
    start_m = 1'b1; tick(); start_m = 1'b0;
    chk("start_edge_ignored", {m_in_ready, m_err, m_seen}, {1'b1, 8'd0, 4'h0});
    send(0, 0, 0, 0, 4'h1, 8'd0, 0, 0, 0);
    send(0, 0, 0, 0, 4'h1, 8'd0, 0, 0, 0);
    start_m = 1'b1;
    send(0, 0, 1, 1, 4'h3, 8'd0, 0, 0, 0);
    start_m = 1'b0;
    send(0, 1, 0, 1, 4'h7, 8'd0, 0, 0, 0);
    send(0, 1, 1, 0, 4'hF, 8'd0, 0, 1, 1);
    in_valid = 1'b0; tick();

    // saturation on the CNT_W=2 instance
    start_s = 1'b1; tick(); start_s = 1'b0;
    chk("sat_start", {s_in_ready, s_err}, {1'b1, 2'd0});
    send(1, 0, 0, 1, 4'h1, 8'd1, 1, 0, 0);
    send(1, 0, 0, 1, 4'h1, 8'd2, 1, 0, 0);
    send(1, 0, 0, 1, 4'h1, 8'd3, 1, 0, 0);
    send(1, 0, 0, 1, 4'h1, 8'd3, 1, 0, 0);
    send(1, 0, 0, 1, 4'h1, 8'd3, 1, 0, 0);
    send(1, 0, 1, 1, 4'h3, 8'd3, 0, 0, 0);
    send(1, 1, 0, 1, 4'h7, 8'd3, 0, 0, 0);
    send(1, 1, 1, 0, 4'hF, 8'd3, 0, 1, 0);
    in_valid = 1'b0; tick();
    chk("main_untouched_by_sat", {m_done, m_pass, m_seen}, {1'b1, 1'b1, 4'hF});

    // reset mid-run, overriding start and a failing transfer
    start_m = 1'b1; tick(); start_m = 1'b0;
    send(0, 0, 0, 0, 4'h1, 8'd0, 0, 0, 0);
    send(0, 0, 1, 0, 4'h3, 8'd1, 1, 0, 0);
    rst_n = 1'b0; start_m = 1'b1; in_valid = 1'b1; a = 1; b = 0; s = 0;
    tick();
    chk_clear("midrun_reset_main", 0);
    chk_clear("midrun_reset_sat", 1);
    rst_n = 1'b1; start_m = 1'b0;
    tick();
    chk("post_reset_idle", {m_in_ready, m_busy, m_seen, m_err}, 32'h0);
    in_valid = 1'b0;
    tick(); tick();

    chk("queue_main_drained", q_m.size(), 32'd0);
    chk("queue_sat_drained", q_s.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/guia_0501_checker.md
# guia_0501_checker

Response checker for the Guia_0501 family of 2-input logic cells. It consumes `(a, b, s)` observation triples through a valid/ready handshake and compares each `s` against an expected 4-entry truth table. It tracks which input rows have been covered and reports pass/fail once all four rows have been seen. It sits on the observing side of a DUT: stimulus hardware or a bench drives the cell, and this block judges the outputs in synthesizable form.

## Interface

Parameters:
- `TRUTH`, default `4'b0110`: expected `s` for each row; index = `{a,b}`, so `TRUTH[2'b11]` is the expected output for `a=1, b=1`.
- `CNT_W`, default `8`: width of the mismatch counter.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `start` input 1: begin or restart a check run (level sampled at the clock edge).
- `in_valid` input 1: the observation triple is valid.
- `in_ready` output 1: the checker accepts observations.
- `a` input 1: DUT input a, as applied.
- `b` input 1: DUT input b, as applied.
- `s` input 1: DUT output observed.
- `busy` output 1: run in progress.
- `done` output 1: all four rows covered; result valid.
- `pass` output 1: `done` and zero mismatches.
- `err_count` output `CNT_W`: mismatches in the current run, saturating.
- `seen` output 4: bit i is set once row i has been accepted.
- `mismatch` output 1: one-cycle pulse after a failing observation is accepted.

## Operation

- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- A transfer occurs on an edge where `in_valid && in_ready`.
- `in_ready` is combinational and equals `(state == RUN)`. Triples presented in IDLE or DONE are ignored and not counted.
- IDLE, `start = 1`:
  - Next state RUN.
  - Clear `err_count`, `seen`, `pass`, `done`.
- RUN, on a transfer, with idx = `{a,b}`:
  - `seen[idx] <= 1`.
  - If `s != TRUTH[idx]`: `err_count <= err_count + 1`, saturating at all-ones, and `mismatch <= 1` for exactly one cycle.
  - Repeated rows are legal; every repeat is checked and counted.
  - If `(seen | onehot(idx)) == 4'hF`: next state DONE, `done <= 1`, and `pass <= (err_count_next == 0)`, where `err_count_next` includes the current sample.
- RUN, `start = 1` with no transfer: ignored; the run continues.
- RUN, `start = 1` together with a transfer: the transfer is processed; `start` is ignored.
- DONE:
  - `done`, `pass`, `err_count`, `seen` hold.
  - `start = 1` behaves exactly as in IDLE: clear everything and go to RUN.
- `busy = (state == RUN)`, registered-equivalent.
- Reset (`rst_n = 0` at an edge), from any state, including mid-run:
  - State goes to IDLE.
  - `done = 0`, `pass = 0`, `err_count = 0`, `seen = 0`, `mismatch = 0`, `busy = 0`.
  - `in_ready = 0` from that edge onward.
  - Reset takes priority over `start` and over any transfer.

## Timing

- Reset values: every output is 0.
- `start` to `in_ready = 1`: 1 cycle, i.e. the edge that samples `start` moves the FSM to RUN.
- Transfer to `seen`/`err_count` update: visible after the accepting edge (latency 1).
- `mismatch` is high during the cycle immediately after the failing transfer, then returns to 0 unless the next transfer also fails.
- Completing transfer to `done = 1`: visible after the same edge. `in_ready` drops in that same following cycle, so at most one observation per cycle is accepted and none after completion.
- Throughput: 1 observation per cycle while in RUN.
- Minimum run length is 4 transfers; there is no upper bound.

## Test plan

1. **Reset:** hold `rst_n = 0` for 2 cycles with `start = 1` and `in_valid = 1`. Required: all outputs 0, `in_ready = 0`, and the FSM stays in IDLE until `start` is asserted after release.
2. **XOR pass:** `TRUTH = 0110`; pulse `start`, then send `00/0`, `01/1`, `10/1`, `11/0` back to back. Required: `seen` goes `1 → 3 → 7 → F`; `done = 1` and `pass = 1` the cycle after the 4th transfer; `err_count = 0`; `mismatch` never asserts.
3. **Single fault:** as in 2, but send `11/1`. Required: `mismatch` pulses for one cycle after that transfer; `err_count = 1`; at completion `done = 1` and `pass = 0`.
4. **Repeats and ignored input:** drive `in_valid` with `00/1` before `start`, which must not be counted. Then send `00/0`, `00/0`, `01/1`, `10/1`, `11/0`. Required: `done` only after the 5th transfer; `err_count = 0`; `pass = 1`.
5. **Saturation:** with `CNT_W = 2`, send five `00/1` triples, then `01/1`, `10/1`, `11/0`. Required: `err_count` sequence `1, 2, 3, 3, 3`; `pass = 0` at done.
6. **Reset mid-run and restart:** after 2 transfers, assert `rst_n = 0` for 1 cycle. Required: all outputs clear at that edge. Then, from DONE in scenario 2, pulse `start`. Required: `done`, `pass`, `seen` clear and `in_ready = 1` on the next cycle.
